// File: rtl/ysyx_24100013_regfile_sb.sv
// Register file with combinational read ports, write bypass and a per-entry
// scoreboard of pending writebacks; entry 0 is hardwired to zero.
module ysyx_24100013_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]            rbusy,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  input  logic                        flush,
  output logic [ADDR_WIDTH:0]         busy_cnt
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic [DATA_WIDTH-1:0] rf_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  set_new;
  logic                  clr_old;

  // The count moves incrementally: an issue only adds when the entry was idle,
  // a writeback only subtracts when it retires a pending entry not re-issued now.
  always_comb begin
    wr_ok   = wen && (waddr != '0);
    iss_ok  = iss_valid && !flush && (iss_rd != '0);
    set_new = iss_ok && !busy_q[iss_rd];
    clr_old = wr_ok && busy_q[waddr] && !(iss_ok && (iss_rd == waddr));

    rf_d = rf_q;
    if (wr_ok) begin
      rf_d[waddr] = wdata;
    end

    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[waddr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (set_new && !clr_old) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (clr_old && !set_new) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Outputs are forced low during reset so a bypassed write cannot leak through.
  for (genvar g = 0; g < NR_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;

    assign ra  = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = wen && (waddr == ra);
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (!rst_n || (ra == '0)) ? '0 : (hit ? wdata : rf_q[ra]);
    assign rbusy[g] = rst_n && busy_q[ra] && !hit;
  end

endmodule
